// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order rename/checkpoint logic.
// Contents:
//   CKPT_ID_W    - default checkpoint ID width
//   NUM_CKPT     - number of checkpoints at the default width
//   ckpt_id_t    - checkpoint ID type at the default width
//   ckpt_state_e - recovery FSM states
package ooo_pkg;

    localparam int unsigned CKPT_ID_W = 2;
    localparam int unsigned NUM_CKPT  = 1 << CKPT_ID_W;

    typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

    typedef enum logic [1:0] {
        IDLE,
        RECOVER,
        DRAIN
    } ckpt_state_e;

endpackage

// File: rtl/ckpt_age_mask.sv
// Squash-mask generator for a circular checkpoint queue.
// Ports:
//   head, tail  in  CKPT_WIDTH+1 - queue pointers, MSB is the wrap bit
//   res_id      in  CKPT_WIDTH   - mispredicted checkpoint
//   squash_mask out 2**CKPT_WIDTH - res_id and every younger live entry
//   new_tail    out CKPT_WIDTH+1 - tail rewound to res_id, wrap bit relative to head
module ckpt_age_mask #(
    parameter int unsigned CKPT_WIDTH = 2
) (
    input  logic [CKPT_WIDTH:0]      head,
    input  logic [CKPT_WIDTH:0]      tail,
    input  logic [CKPT_WIDTH-1:0]    res_id,
    output logic [2**CKPT_WIDTH-1:0] squash_mask,
    output logic [CKPT_WIDTH:0]      new_tail
);

    localparam int unsigned N = 2**CKPT_WIDTH;

    logic [CKPT_WIDTH-1:0] head_idx;
    logic [CKPT_WIDTH-1:0] res_off;
    logic [CKPT_WIDTH:0]   count;

    always_comb begin
        head_idx = head[CKPT_WIDTH-1:0];
        count    = tail - head;
        // Age of res_id measured from head; modulo arithmetic handles wrap.
        res_off  = res_id - head_idx;
        // Adding the age to the full head pointer rebuilds the correct wrap bit.
        new_tail = head + {1'b0, res_off};
        squash_mask = '0;
        for (int i = 0; i < N; i++) begin
            logic [CKPT_WIDTH-1:0] ent_off;
            ent_off = CKPT_WIDTH'(i) - head_idx;
            squash_mask[i] = (ent_off >= res_off) && ({1'b0, ent_off} < count);
        end
    end

endmodule

// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint controller for the rename stage.
// Grants in-order checkpoint IDs, stalls decode when all are live, tracks
// out-of-order resolution and runs a fixed-length recovery on a mispredict.
// Ports:
//   clk, reset                         - clock, async active-high reset
//   dec_valid, dec_is_branch           - decode request
//   rename_ready                       - rename backpressure
//   ckpt_grant, ckpt_id, ckpt_full     - allocation result (combinational)
//   decode_stall                       - hold decode (combinational)
//   res_valid, res_id, res_mispredict  - branch resolution
//   branch_mispredict                  - one-cycle restore pulse
//   flush, restore_id                  - recovery window and restored checkpoint
//   live_count                         - allocated, unreleased checkpoints
module branch_ckpt_ctrl
    import ooo_pkg::*;
#(
    parameter int unsigned CKPT_WIDTH      = 2,
    parameter int unsigned RECOVERY_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_valid,
    input  logic                  dec_is_branch,
    input  logic                  rename_ready,
    output logic                  ckpt_grant,
    output logic [CKPT_WIDTH-1:0] ckpt_id,
    output logic                  ckpt_full,
    output logic                  decode_stall,
    input  logic                  res_valid,
    input  logic [CKPT_WIDTH-1:0] res_id,
    input  logic                  res_mispredict,
    output logic                  branch_mispredict,
    output logic                  flush,
    output logic [CKPT_WIDTH-1:0] restore_id,
    output logic [CKPT_WIDTH:0]   live_count
);

    localparam int unsigned N     = 2**CKPT_WIDTH;
    localparam int unsigned CNT_W = $clog2(RECOVERY_CYCLES + 1);

    ckpt_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CKPT_WIDTH:0]   head_q, head_d, tail_q, tail_d;
    logic [N-1:0]          live_q, live_d, resolved_q, resolved_d;
    logic [CKPT_WIDTH-1:0] restore_q, restore_d;

    logic [CKPT_WIDTH-1:0] head_idx, tail_idx;
    logic [N-1:0]          squash_mask;
    logic [CKPT_WIDTH:0]   new_tail;
    logic                  recover_start, correct_res, release_head;

    ckpt_age_mask #(
        .CKPT_WIDTH (CKPT_WIDTH)
    ) u_age_mask (
        .head        (head_q),
        .tail        (tail_q),
        .res_id      (res_id),
        .squash_mask (squash_mask),
        .new_tail    (new_tail)
    );

    always_comb begin
        head_idx      = head_q[CKPT_WIDTH-1:0];
        tail_idx      = tail_q[CKPT_WIDTH-1:0];
        live_count    = tail_q - head_q;
        ckpt_full     = (live_count == (CKPT_WIDTH+1)'(N));
        recover_start = res_valid & res_mispredict & live_q[res_id];
        correct_res   = res_valid & ~res_mispredict & live_q[res_id];
        release_head  = live_q[head_idx] & resolved_q[head_idx];
        ckpt_grant    = dec_valid & dec_is_branch & rename_ready & ~ckpt_full
                        & (state_q == IDLE) & ~recover_start;
        ckpt_id       = tail_idx;
        decode_stall  = (dec_valid & dec_is_branch & ckpt_full) | (state_q != IDLE)
                        | recover_start;
        branch_mispredict = (state_q == RECOVER);
        flush             = (state_q != IDLE);
        restore_id        = restore_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        live_d     = live_q;
        resolved_d = resolved_q;
        restore_d  = restore_q;

        if (release_head) begin
            live_d[head_idx] = 1'b0;
            head_d           = head_q + 1'b1;
        end
        if (correct_res) begin
            resolved_d[res_id] = 1'b1;
        end
        if (ckpt_grant) begin
            live_d[tail_idx]     = 1'b1;
            resolved_d[tail_idx] = 1'b0;
            tail_d               = tail_q + 1'b1;
        end

        if (recover_start) begin
            // A new mispredict always wins, including one arriving mid-recovery.
            tail_d    = new_tail;
            live_d    = live_d & ~squash_mask;
            restore_d = res_id;
            state_d   = RECOVER;
        end else begin
            unique case (state_q)
                RECOVER: begin
                    if (RECOVERY_CYCLES >= 2) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(RECOVERY_CYCLES - 2);
                    end else begin
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            live_q     <= '0;
            resolved_q <= '0;
            restore_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            live_q     <= live_d;
            resolved_q <= resolved_d;
            restore_q  <= restore_d;
        end
    end

endmodule
